// File: rtl/stream_argminmax_pkg.sv
// Shared definitions for the streaming arg-min/arg-max block.
//   state_e  : controller state encoding (IDLE/SCAN/DONE, two bits)
//   MODE_*   : run mode select values sampled with start
package stream_argminmax_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_MIN = 1'b0;
    localparam logic MODE_MAX = 1'b1;

endpackage

// File: rtl/argminmax_cmp.sv
// Strict "better than" comparator for the arg-min/arg-max search.
//   candidate : operand under test
//   best      : current best operand
//   mode      : MODE_MIN -> better when candidate < best, MODE_MAX -> when >
//   better    : strict result; equality is never better, so ties keep the
//               earlier (lower-index) operand
module argminmax_cmp
    import stream_argminmax_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter bit SIGNED = 1'b0
) (
    input  logic [WIDTH-1:0] candidate,
    input  logic [WIDTH-1:0] best,
    input  logic             mode,
    output logic             better
);

    logic lt;
    logic gt;

    generate
        if (SIGNED) begin : g_signed
            assign lt = $signed(candidate) < $signed(best);
            assign gt = $signed(candidate) > $signed(best);
        end else begin : g_unsigned
            assign lt = candidate < best;
            assign gt = candidate > best;
        end
    endgenerate

    assign better = (mode == MODE_MIN) ? lt : gt;

endmodule

// File: rtl/stream_argminmax.sv
// Streaming arg-min/arg-max: takes COUNT operands one per accepted beat and
// reports the extreme value and its arrival index.
//   clk, rst_n          : clock, async active-low reset
//   start, mode         : begin a run (IDLE, or DONE on the result handshake)
//   in_valid/in_ready   : operand stream, in_data operand
//   out_valid/out_ready : result stream, out_value/out_idx result
//   busy                : run in progress (SCAN or DONE)
module stream_argminmax
    import stream_argminmax_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int COUNT  = 4,
    parameter int IDX_W  = (COUNT > 1) ? $clog2(COUNT) : 1,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic [IDX_W-1:0] out_idx,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(COUNT - 1);

    state_e           state;
    state_e           state_d;
    logic             mode_q;
    logic [IDX_W-1:0] count;
    logic [WIDTH-1:0] best_val;
    logic [IDX_W-1:0] best_idx;
    logic             take_run;
    logic             accept;
    logic             better;

    // Ready comes from registered state only, so in_valid never loops back.
    assign in_ready  = (state == ST_SCAN);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign accept    = in_valid & in_ready;
    assign out_value = best_val;
    assign out_idx   = best_idx;

    argminmax_cmp #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_cmp (
        .candidate (in_data),
        .best      (best_val),
        .mode      (mode_q),
        .better    (better)
    );

    always_comb begin
        state_d  = state;
        take_run = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SCAN;
                    take_run = 1'b1;
                end
            end
            ST_SCAN: begin
                if (accept && count == LAST) state_d = ST_DONE;
            end
            ST_DONE: begin
                // A start on the handshake cycle chains straight into the next run.
                if (out_ready) begin
                    if (start) begin
                        state_d  = ST_SCAN;
                        take_run = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_MIN;
            count    <= '0;
            best_val <= '0;
            best_idx <= '0;
        end else begin
            state <= state_d;
            if (take_run) begin
                mode_q <= mode;
                count  <= '0;
            end else if (accept) begin
                count <= count + 1'b1;
                // First operand seeds the search regardless of its value.
                if (count == '0 || better) begin
                    best_val <= in_data;
                    best_idx <= count;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_argminmax.sv
// Self-checking bench: two instances (unsigned and signed) share one stimulus
// stream; a queue-based model recomputes each run's extreme by direct scan.
module tb_stream_argminmax;

    localparam int W  = 3;
    localparam int N  = 4;
    localparam int IW = 2;

    typedef logic [W-1:0] ops_t [N];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          out_ready = 1'b0;

    logic          in_ready_u, out_valid_u, busy_u;
    logic [W-1:0]  val_u;
    logic [IW-1:0] idx_u;
    logic          in_ready_s, out_valid_s, busy_s;
    logic [W-1:0]  val_s;
    logic [IW-1:0] idx_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stream_argminmax #(.WIDTH(W), .COUNT(N), .IDX_W(IW), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data),
        .out_valid(out_valid_u), .out_ready(out_ready),
        .out_value(val_u), .out_idx(idx_u), .busy(busy_u));

    stream_argminmax #(.WIDTH(W), .COUNT(N), .IDX_W(IW), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_value(val_s), .out_idx(idx_s), .busy(busy_s));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           ph = 0;     // 0 idle, 1 collecting, 2 result held
    bit           mq = 1'b0;
    logic [W-1:0] q[$];
    logic [W-1:0] ev_u = '0, ev_s = '0;
    int           ei_u = 0, ei_s = 0;

    function automatic int key(input logic [W-1:0] x, input bit sg);
        return (sg && x[W-1]) ? int'(x) - (1 << W) : int'(x);
    endfunction

    function automatic void extreme(input bit sg, input bit mx,
                                    output logic [W-1:0] v, output int ix);
        int b = 0;
        for (int k = 1; k < q.size(); k++) begin
            if (mx ? key(q[k], sg) > key(q[b], sg) : key(q[k], sg) < key(q[b], sg))
                b = k;
        end
        v  = q[b];
        ix = b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = 0;
            mq = 1'b0;
            q.delete();
        end else begin
            case (ph)
                0: if (start) begin ph = 1; mq = mode; q.delete(); end
                1: if (in_valid) begin
                    q.push_back(in_data);
                    if (q.size() == N) begin
                        extreme(1'b0, mq, ev_u, ei_u);
                        extreme(1'b1, mq, ev_s, ei_s);
                        ph = 2;
                    end
                end
                default: if (out_ready) begin
                    if (start) begin ph = 1; mq = mode; q.delete(); end
                    else ph = 0;
                end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("m_in_ready_u",  in_ready_u,  ph == 1);
        chk("m_out_valid_u", out_valid_u, ph == 2);
        chk("m_busy_u",      busy_u,      ph != 0);
        chk("m_in_ready_s",  in_ready_s,  ph == 1);
        chk("m_out_valid_s", out_valid_s, ph == 2);
        chk("m_busy_s",      busy_s,      ph != 0);
        if (ph == 2) begin
            chk("m_val_u", val_u, ev_u);
            chk("m_idx_u", idx_u, ei_u);
            chk("m_val_s", val_s, ev_s);
            chk("m_idx_s", idx_s, ei_s);
        end
        if (!rst_n) begin
            chk("m_rst_val_u", val_u, 0);
            chk("m_rst_idx_u", idx_u, 0);
            chk("m_rst_val_s", val_s, 0);
            chk("m_rst_idx_s", idx_s, 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gap < 0 selects random bubbles; lit enables the hand-computed checks.
    task automatic run(input bit m, input bit skip_start, input ops_t d,
                       input int gap, input int stall, input bit chain, input bit nm,
                       input bit lit, input int euv, input int eui,
                       input int esv, input int esi);
        int g;
        if (!skip_start) begin
            start = 1'b1; mode = m;
            tick();
            start = 1'b0; mode = ~m;
            chk("busy_after_start", busy_u, 1);
        end else begin
            chk("b2b_no_idle", in_ready_u, 1);
        end
        for (int k = 0; k < N; k++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
                start    = (gap < 0) ? 1'($urandom) : 1'b0;
                mode     = 1'($urandom);
                tick();
            end
            start = 1'b0;
            in_valid = 1'b1;
            in_data  = d[k];
            tick();
        end
        in_valid = 1'b0;
        chk("latency_valid", out_valid_u, 1);
        if (lit) begin
            chk("lit_val_u", val_u, euv);
            chk("lit_idx_u", idx_u, eui);
            chk("lit_val_s", val_s, esv);
            chk("lit_idx_s", idx_s, esi);
        end
        for (int c = 0; c < stall; c++) begin
            start = 1'($urandom);
            mode  = 1'($urandom);
            tick();
            chk("stall_valid", out_valid_u, 1);
            chk("stall_ready", in_ready_u, 0);
            if (lit) begin
                chk("stall_val_u", val_u, euv);
                chk("stall_idx_u", idx_u, eui);
            end
        end
        out_ready = 1'b1;
        start = chain;
        mode  = nm;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        ops_t d;
        bit   skip;
        bit   ch;
        bit   nmode;

        tick(); tick();
        chk("rst_in_ready", in_ready_u, 0);
        chk("rst_out_valid", out_valid_u, 0);
        chk("rst_busy", busy_u, 0);
        chk("rst_val", val_u, 0);
        chk("rst_idx", idx_u, 0);
        rst_n = 1'b1;
        tick();

        // min 0,1,2,3
        run(1'b0, 1'b0, '{3'd0, 3'd1, 3'd2, 3'd3}, 0, 0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
        chk("idle_after_hs", busy_u, 0);
        // min with a clear winner, then a tie
        run(1'b0, 1'b0, '{3'd2, 3'd1, 3'd2, 3'd3}, 0, 1, 1'b0, 1'b0, 1'b1, 1, 1, 1, 1);
        run(1'b0, 1'b0, '{3'd2, 3'd3, 3'd2, 3'd3}, 0, 0, 1'b0, 1'b0, 1'b1, 2, 0, 2, 0);
        // max then min back-to-back
        run(1'b1, 1'b0, '{3'd7, 3'd7, 3'd6, 3'd2}, 0, 0, 1'b1, 1'b0, 1'b1, 7, 0, 2, 3);
        run(1'b0, 1'b1, '{3'd7, 3'd7, 3'd6, 3'd2}, 0, 0, 1'b0, 1'b0, 1'b1, 2, 3, 6, 2);
        // alternate bubbles, 5-cycle result stall
        run(1'b0, 1'b0, '{3'd1, 3'd5, 3'd0, 3'd4}, 1, 5, 1'b0, 1'b0, 1'b1, 0, 2, 4, 3);
        // signed vs unsigned
        run(1'b0, 1'b0, '{3'd3, 3'd7, 3'd4, 3'd1}, 0, 0, 1'b0, 1'b0, 1'b1, 1, 3, 4, 2);

        // reset mid-run after two operands
        start = 1'b1; mode = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 3'd7; tick();
        in_data = 3'd6; tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", in_ready_u, 0);
        chk("abort_busy", busy_u, 0);
        chk("abort_out_valid", out_valid_u, 0);
        chk("abort_val", val_u, 0);
        chk("abort_idx", idx_u, 0);
        tick();
        rst_n = 1'b1;
        tick();
        run(1'b0, 1'b0, '{3'd6, 3'd5, 3'd4, 3'd3}, 0, 0, 1'b0, 1'b0, 1'b1, 3, 3, 4, 2);

        // randomized runs, model-checked
        skip = 1'b0;
        nmode = 1'b0;
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < N; k++) d[k] = W'($urandom);
            ch = 1'($urandom);
            run(skip ? nmode : 1'($urandom), skip, d, -1, int'($urandom_range(0, 3)),
                ch, nmode, 1'b0, 0, 0, 0, 0);
            skip  = ch;
            nmode = 1'($urandom);
            if (ch) begin
                // next iteration's mode is the one latched on the handshake
            end
        end
        if (skip) begin
            for (int k = 0; k < N; k++) d[k] = W'($urandom);
            run(1'b0, 1'b1, d, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        end
        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_argminmax.md
Name: stream_argminmax

Overview:
- Sequential, parametrised successor to the four-input combinational minimum-index selector.
- Accepts COUNT operands of WIDTH bits, one per cycle, over a valid/ready stream.
- Returns the extreme value and its index over a valid/ready result port.
- Extreme is minimum or maximum, selected per run; operands are unsigned or signed via parameter.
- Sits between an operand producer (register file or FIFO) and a consumer that needs the winning index.

Parameters:
- WIDTH, 3: operand width in bits (>=1).
- COUNT, 4: operands per run (>=1).
- IDX_W, $clog2(COUNT) (minimum 1): index width.
- SIGNED, 0: 1 = compare operands as two's complement.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a run; honoured only when the block can accept a run (see Behaviour).
- mode  input  1  0 = find minimum, 1 = find maximum; sampled with start.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts an operand this cycle.
- in_data  input  WIDTH  operand.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer takes the result.
- out_value  output  WIDTH  extreme operand value.
- out_idx  output  IDX_W  arrival index (0-based) of the extreme operand.
- busy  output  1  high in SCAN or DONE.

Behaviour:
- States:
  - IDLE: waiting for start.
  - SCAN: collecting operands.
  - DONE: holding the result.
  - Two-bit encoding.
- Reset (async assert, sync release):
  - State goes to IDLE.
  - in_ready=0, out_valid=0, out_value=0, out_idx=0, busy=0.
  - Internal count=0 and mode_q=0.
- IDLE:
  - start=1 latches mode into mode_q, clears count, and moves to SCAN next cycle.
  - in_valid is ignored in IDLE.
- SCAN:
  - in_ready=1, decoded from registered state only; no combinational path from in_valid.
  - Accept = in_valid & in_ready.
  - On accept with count==0, unconditionally load best_val=in_data and best_idx=0.
  - On accept with count>0, replace only if in_data is strictly better (less for min, greater for max). Ties keep the lower index.
  - count increments on each accept; cycles without accept (bubbles) change nothing.
  - The accept with count==COUNT-1 moves to DONE. out_valid rises on the following clock edge, with out_value/out_idx already final.
  - Latency: 1 cycle from last accepted operand to out_valid.
  - Minimum run length: COUNT+1 cycles after start.
- DONE:
  - out_valid=1, in_ready=0.
  - out_value and out_idx are held stable until out_ready=1.
  - Handshake cycle (out_valid & out_ready):
    - With start=0, go to IDLE; out_valid falls next cycle.
    - With start=1, the new run is accepted: mode latched, count cleared, go directly to SCAN (back-to-back runs).
- start and mode are ignored in SCAN, and in DONE without out_ready. mode changes mid-run have no effect.
- Comparison:
  - SIGNED=0: unsigned magnitude.
  - SIGNED=1: MSB is the sign bit.
  - No widening; equal widths only.
- COUNT=1: the single operand is the result, with index 0.
- out_value/out_idx outside DONE are don't-care for consumers, but must hold their last value (no X after reset).
- rst_n low at any time aborts the run immediately. Partial results are discarded and outputs return to reset values asynchronously.

Decomposition:
- Shared package:
  - State encoding constants (ST_IDLE=0, ST_SCAN=1, ST_DONE=2).
  - Mode constants (MODE_MIN=0, MODE_MAX=1).
- Sub-module argminmax_cmp:
  - Combinational, parametrised by WIDTH and SIGNED.
  - Inputs: candidate, best, mode. Output: better (strict).
  - Reused by future tree/parallel variants.

Test Plan:
- Default params, min, stream 0,1,2,3 without bubbles -> out_valid 1 cycle after 4th accept; out_value=0, out_idx=0; busy high from the cycle after start through the handshake.
- Min, stream 2,1,2,3, then min 2,3,2,3 -> first run value=1 idx=1; second run value=2 idx=0 (tie keeps lower index).
- Max, stream 7,7,6,2; then min with the same data, back-to-back via start with the out_ready handshake -> max run value=7 idx=0; min run value=2 idx=3; no idle cycle between runs.
- Min, 1,5,0,4 with in_valid low on alternate cycles, and out_ready held low 5 cycles -> result value=0 idx=2 once all 4 operands are in; out_valid and result held stable for all 5 stall cycles; in_ready=0 throughout DONE.
- SIGNED=1, min, stream 3,7(-1),4(-4),1 -> value=3'b100, idx=2; same data with SIGNED=0 -> value=1, idx=3.
- Reset pulse after 2 operands accepted -> outputs immediately at reset values and state IDLE; a fresh min run of 6,5,4,3 gives value=3 idx=3 (no stale data).
